time_of_day_counter: RTL and testbench
======================================

// Module: time_of_day_counter
// PURPOSE
//  BCD hours:minutes:seconds time-of-day counter, driven by the 1 Hz/2 Hz tick
//  pulses of the 50 MHz clock divider. Two push-buttons (mode, inc) set HH/MM.
//  Outputs feed the 7-segment display driver, including per-field blink blanking.
// PARAMETERS
//  HOURS_24     1  1: hours 00..23, reset 00; 0: hours 01..12, reset 12
//  SYNC_STAGES  2  flops in each button synchroniser (>=2)
// PORTS
//  clk_in    in   1  50 MHz system clock, all state on posedge
//  rst_n     in   1  asynchronous, active-low reset
//  s_tick    in   1  1 Hz tick, one clk_in cycle high
//  hs_tick   in   1  2 Hz tick, one clk_in cycle high
//  btn_mode  in   1  raw mode button, asynchronous, active high
//  btn_inc   in   1  raw increment button, asynchronous, active high
//  hh_bcd    out  8  hours, {tens,units} BCD
//  mm_bcd    out  8  minutes, BCD
//  ss_bcd    out  8  seconds, BCD
//  blank_hh  out  1  1 = display blanks hour digits
//  blank_mm  out  1  1 = display blanks minute digits
//  mode      out  2  current FSM state (tod_mode_t)
//  day_wrap  out  1  one-cycle pulse when hours wrap
// BEHAVIOUR
//  - Reset (async assert, sync release): hh=00 (12 if !HOURS_24), mm=ss=00,
//    mode=TOD_RUN, blank_hh=blank_mm=0, day_wrap=0, synchronisers cleared.
//  - All outputs registered. Event sampled in cycle N is visible at N+1.
//  - Buttons: SYNC_STAGES-flop synchroniser. Level resampled only on hs_tick
//    (debounce). Press = 0->1 change between consecutive hs_tick samples,
//    giving a one-cycle press strobe in the hs_tick cycle.
//  - FSM tod_mode_t: TOD_RUN -mode-> TOD_SET_HH -mode-> TOD_SET_MM -mode-> TOD_RUN.
//  - TOD_RUN: on s_tick, ss+1. ss 59->00 carries mm+1. mm 59->00 carries hh+1.
//    Hour wrap: 23->00 (24h) or 12->01 (12h), with day_wrap=1 for that cycle only.
//    12h: 11->12 is a plain increment with no wrap pulse. inc press is ignored.
//  - Entering TOD_SET_HH clears ss to 00. In both SET states, s_tick is ignored.
//  - TOD_SET_HH: inc press does hh+1 with hour wrap rule, no carry, no day_wrap.
//  - TOD_SET_MM: inc press does mm 59->00 wrap, no carry into hh.
//  - Leaving TOD_SET_MM resumes counting from ss=00 on the next s_tick.
//  - Blink: in TOD_SET_HH, blank_hh toggles on every hs_tick (1 Hz, 50%).
//    It starts at 0 on state entry. Same for blank_mm in TOD_SET_MM.
//    A blank signal is forced 0 in every other state.
//  - Simultaneous events: mode and inc presses share one hs_tick cycle, so both
//    can occur together. Then mode wins and inc is dropped.
//    mode press with s_tick in TOD_RUN: the transition wins, ss is cleared and
//    the tick is lost. s_tick with hs_tick: both are processed.
//  - Arithmetic: per-nibble BCD. Units 9->0 carries into tens. Nibble >9 is
//    unreachable and gets an assertion in simulation.
//  - rst_n asserted mid-operation (any state/mid-carry): outputs immediately
//    take reset values. No partial update survives.
// STRUCTURE
//  - tod_pkg:
//    - typedef enum logic[1:0] {TOD_RUN, TOD_SET_HH, TOD_SET_MM} tod_mode_t
//    - localparams for BCD 59, 23, 12, 01
//    - function bcd_inc(input [7:0] v, input [7:0] max, input [7:0] min)
//      returns {wrap, next}
//  - Sub-module bcd_mod_counter: params MAX, MIN, RST. Ports clk_in, rst_n,
//    inc, load_zero -> q[7:0], wrap. Instantiated for ss/mm/hh.
//  - Synchronisers, press detection, FSM and blink stay in this module.
// TESTING
//  1. Release reset -> 00:00:00, mode=TOD_RUN, blanks 0, day_wrap 0.
//  2. 10 s_ticks from reset -> ss_bcd=8'h10 (BCD carry, not 8'h0A).
//  3. Set 23:59 via buttons, return to TOD_RUN, 59 s_ticks -> 23:59:59. Next s_tick
//     -> 00:00:00, day_wrap high exactly 1 cycle.
//  4. At 00:00:37 press mode -> TOD_SET_HH, ss=00, blank_hh toggles each hs_tick.
//     3 inc presses -> hh=8'h03. s_ticks ignored. mode x2 -> TOD_RUN, mm unchanged.
//  5. s_tick in the same cycle as a mode press in TOD_RUN -> TOD_SET_HH, ss=00.
//     Also mode+inc in one hs_tick -> only the state changes.
//  6. rst_n low mid TOD_SET_MM at 14:27 -> outputs reset the same cycle
//     (async), mode=TOD_RUN.
//  7. HOURS_24=0: reset 12:00:00. Set 12:59, 60 s_ticks -> 01:00:00, day_wrap pulse.

Source files
------------

// File: rtl/tod_pkg.sv
// Shared types and BCD helpers for the time-of-day counter.
package tod_pkg;

    typedef enum logic [1:0] {
        TOD_RUN    = 2'd0,
        TOD_SET_HH = 2'd1,
        TOD_SET_MM = 2'd2
    } tod_mode_t;

    localparam logic [7:0] BCD_00 = 8'h00;
    localparam logic [7:0] BCD_01 = 8'h01;
    localparam logic [7:0] BCD_12 = 8'h12;
    localparam logic [7:0] BCD_23 = 8'h23;
    localparam logic [7:0] BCD_59 = 8'h59;

    // Returns {wrap, next}: max rolls over to min, units 9 carries into tens.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v,
                                           input logic [7:0] max,
                                           input logic [7:0] min);
        logic [8:0] r;
        if (v == max)
            r = {1'b1, min};
        else if (v[3:0] == 4'd9)
            r = {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter with MIN..MAX range and combinational carry out.
module bcd_mod_counter
    import tod_pkg::*;
#(
    parameter logic [7:0] MAX = BCD_59,
    parameter logic [7:0] MIN = BCD_00,
    parameter logic [7:0] RST = BCD_00
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       load_zero,
    output logic [7:0] q,
    output logic       wrap
);

    logic [8:0] step;

    assign step = bcd_inc(q, MAX, MIN);
    assign wrap = inc & ~load_zero & step[8];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)
            q <= RST;
        else if (load_zero)
            q <= BCD_00;
        else if (inc)
            q <= step[7:0];
    end

    nibble_in_range: assert property (@(posedge clk_in) disable iff (!rst_n)
        (q[7:4] <= 4'd9) && (q[3:0] <= 4'd9));

endmodule

// File: rtl/time_of_day_counter.sv
// HH:MM:SS BCD clock with two-button hour/minute setting and blink blanking.
module time_of_day_counter
    import tod_pkg::*;
#(
    parameter bit HOURS_24    = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       s_tick,
    input  logic       hs_tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [7:0] hh_bcd,
    output logic [7:0] mm_bcd,
    output logic [7:0] ss_bcd,
    output logic       blank_hh,
    output logic       blank_mm,
    output logic [1:0] mode,
    output logic       day_wrap
);

    localparam logic [7:0] HH_MAX = HOURS_24 ? BCD_23 : BCD_12;
    localparam logic [7:0] HH_MIN = HOURS_24 ? BCD_00 : BCD_01;
    localparam logic [7:0] HH_RST = HOURS_24 ? BCD_00 : BCD_12;

    tod_mode_t state, state_next;

    logic [SYNC_STAGES-1:0] mode_sync, inc_sync;
    logic mode_smp, inc_smp;
    logic mode_press, inc_press;
    logic ss_clr, ss_inc, ss_wrap;
    logic mm_inc, mm_wrap;
    logic hh_inc, hh_wrap;

    // Buttons are only resampled on hs_tick, which debounces contact bounce.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            mode_sync <= '0;
            inc_sync  <= '0;
            mode_smp  <= 1'b0;
            inc_smp   <= 1'b0;
        end else begin
            mode_sync <= {mode_sync[SYNC_STAGES-2:0], btn_mode};
            inc_sync  <= {inc_sync[SYNC_STAGES-2:0], btn_inc};
            if (hs_tick) begin
                mode_smp <= mode_sync[SYNC_STAGES-1];
                inc_smp  <= inc_sync[SYNC_STAGES-1];
            end
        end
    end

    assign mode_press = hs_tick & mode_sync[SYNC_STAGES-1] & ~mode_smp;
    assign inc_press  = hs_tick & inc_sync[SYNC_STAGES-1] & ~inc_smp;

    // NOTE: the default assignment first keeps this combinational block from inferring a latch.
    always_comb begin
        state_next = state;
        if (mode_press) begin
            case (state)
                TOD_RUN:    state_next = TOD_SET_HH;
                TOD_SET_HH: state_next = TOD_SET_MM;
                default:    state_next = TOD_RUN;
            endcase
        end
    end

    // A mode press outranks both the seconds tick and a simultaneous inc press.
    assign ss_clr = mode_press & (state == TOD_RUN);
    assign ss_inc = s_tick & ~mode_press & (state == TOD_RUN);
    assign mm_inc = ss_wrap | (inc_press & ~mode_press & (state == TOD_SET_MM));
    assign hh_inc = (mm_wrap & (state == TOD_RUN))
                  | (inc_press & ~mode_press & (state == TOD_SET_HH));

    bcd_mod_counter #(.MAX(BCD_59), .MIN(BCD_00), .RST(BCD_00)) u_ss (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .inc       (ss_inc),
        .load_zero (ss_clr),
        .q         (ss_bcd),
        .wrap      (ss_wrap)
    );

    bcd_mod_counter #(.MAX(BCD_59), .MIN(BCD_00), .RST(BCD_00)) u_mm (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .inc       (mm_inc),
        .load_zero (1'b0),
        .q         (mm_bcd),
        .wrap      (mm_wrap)
    );

    bcd_mod_counter #(.MAX(HH_MAX), .MIN(HH_MIN), .RST(HH_RST)) u_hh (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .inc       (hh_inc),
        .load_zero (1'b0),
        .q         (hh_bcd),
        .wrap      (hh_wrap)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state    <= TOD_RUN;
            blank_hh <= 1'b0;
            blank_mm <= 1'b0;
            day_wrap <= 1'b0;
        end else begin
            state    <= state_next;
            blank_hh <= (state == TOD_SET_HH && !mode_press) ? (blank_hh ^ hs_tick) : 1'b0;
            blank_mm <= (state == TOD_SET_MM && !mode_press) ? (blank_mm ^ hs_tick) : 1'b0;
            day_wrap <= hh_wrap & (state == TOD_RUN);
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Self-checking bench: a 24h and a 12h instance share stimulus, checked against an integer model.
module tb_time_of_day_counter;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic rst_n, s_tick, hs_tick, btn_mode, btn_inc;
    logic [7:0] a_hh, a_mm, a_ss, b_hh, b_mm, b_ss;
    logic a_bh, a_bm, a_dw, b_bh, b_bm, b_dw;
    logic [1:0] a_mode, b_mode;
    logic [28:0] obs [2];

    int checks = 0;
    int errors = 0;

    // Model state: index 0 = 24h instance, 1 = 12h instance.
    int m_h[2], m_m[2], m_s[2], m_md[2];
    bit m_bh[2], m_bm[2], m_dw[2];
    bit samp_mode, samp_inc;

    time_of_day_counter #(.HOURS_24(1'b1), .SYNC_STAGES(2)) dut_a (
        .clk_in(clk_in), .rst_n(rst_n), .s_tick(s_tick), .hs_tick(hs_tick),
        .btn_mode(btn_mode), .btn_inc(btn_inc),
        .hh_bcd(a_hh), .mm_bcd(a_mm), .ss_bcd(a_ss),
        .blank_hh(a_bh), .blank_mm(a_bm), .mode(a_mode), .day_wrap(a_dw)
    );

    time_of_day_counter #(.HOURS_24(1'b0), .SYNC_STAGES(2)) dut_b (
        .clk_in(clk_in), .rst_n(rst_n), .s_tick(s_tick), .hs_tick(hs_tick),
        .btn_mode(btn_mode), .btn_inc(btn_inc),
        .hh_bcd(b_hh), .mm_bcd(b_mm), .ss_bcd(b_ss),
        .blank_hh(b_bh), .blank_mm(b_bm), .mode(b_mode), .day_wrap(b_dw)
    );

    assign obs[0] = {a_hh, a_mm, a_ss, a_bh, a_bm, a_mode, a_dw};
    assign obs[1] = {b_hh, b_mm, b_ss, b_bh, b_bm, b_mode, b_dw};

    function automatic logic [7:0] bcd(input int x);
        return {4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic logic [28:0] exp_vec(input int c);
        return {bcd(m_h[c]), bcd(m_m[c]), bcd(m_s[c]), m_bh[c], m_bm[c], 2'(m_md[c]), m_dw[c]};
    endfunction

    function automatic int next_hour(input int c, input int h);
        return (c == 0) ? (h + 1) % 24 : (h % 12) + 1;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_h[c] = (c == 0) ? 0 : 12;
            m_m[c] = 0; m_s[c] = 0; m_md[c] = 0;
            m_bh[c] = 0; m_bm[c] = 0; m_dw[c] = 0;
        end
        samp_mode = 0;
        samp_inc  = 0;
    endtask

    task automatic model_step(input bit st, input bit hst);
        bit mp, ip;
        mp = hst && btn_mode && !samp_mode;
        ip = hst && btn_inc && !samp_inc;
        if (hst) begin
            samp_mode = btn_mode;
            samp_inc  = btn_inc;
        end
        for (int c = 0; c < 2; c++) begin
            m_dw[c] = 0;
            case (m_md[c])
                0: begin
                    if (mp) begin
                        m_md[c] = 1; m_s[c] = 0; m_bh[c] = 0;
                    end else if (st) begin
                        m_s[c]++;
                        if (m_s[c] == 60) begin
                            m_s[c] = 0; m_m[c]++;
                            if (m_m[c] == 60) begin
                                m_m[c] = 0;
                                m_h[c] = next_hour(c, m_h[c]);
                                m_dw[c] = (m_h[c] == ((c == 0) ? 0 : 1));
                            end
                        end
                    end
                end
                1: begin
                    if (mp) begin
                        m_md[c] = 2; m_bh[c] = 0; m_bm[c] = 0;
                    end else begin
                        if (hst) m_bh[c] = !m_bh[c];
                        if (ip) m_h[c] = next_hour(c, m_h[c]);
                    end
                end
                default: begin
                    if (mp) begin
                        m_md[c] = 0; m_bm[c] = 0;
                    end else begin
                        if (hst) m_bm[c] = !m_bm[c];
                        if (ip) m_m[c] = (m_m[c] + 1) % 60;
                    end
                end
            endcase
        end
    endtask

    // One clock: drive ticks after a negedge, advance the model at the posedge, return on negedge.
    task automatic cyc(input bit st, input bit hst);
        s_tick  = st;
        hs_tick = hst;
        @(posedge clk_in);
        model_step(st, hst);
        @(negedge clk_in);
        s_tick  = 1'b0;
        hs_tick = 1'b0;
    endtask

    task automatic press(input bit m, input bit i, input bit st);
        btn_mode = m;
        btn_inc  = i;
        repeat (3) cyc(0, 0);
        cyc(st, 1);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (3) cyc(0, 0);
        cyc(0, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; s_tick = 1'b0; hs_tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs[0] !== {8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0}) begin
            errors++; $display("FAIL reset_24h got %h expected %h", obs[0], {8'h00, 8'h00, 8'h00, 5'd0});
        end
        checks++;
        if (obs[1] !== {8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0}) begin
            errors++; $display("FAIL reset_12h got %h expected %h", obs[1], {8'h12, 8'h00, 8'h00, 5'd0});
        end
        cyc(0, 0);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (obs[c] !== exp_vec(c)) begin
                errors++; $display("FAIL reset_hold dut%0d got %h expected %h", c, obs[c], exp_vec(c));
            end
        end
    endtask

    task automatic test_seconds_carry();
        repeat (10) cyc(1, 0);
        checks++;
        if (a_ss !== 8'h10) begin
            errors++; $display("FAIL ss_bcd_carry got %h expected 10", a_ss);
        end
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (obs[c] !== exp_vec(c)) begin
                errors++; $display("FAIL seconds_carry dut%0d got %h expected %h", c, obs[c], exp_vec(c));
            end
        end
    endtask

    task automatic test_day_wrap();
        press(1, 0, 0);
        repeat (23) press(0, 1, 0);
        press(1, 0, 0);
        repeat (59) press(0, 1, 0);
        press(1, 0, 0);
        checks++;
        if ({a_hh, a_mm, a_ss, a_mode} !== {8'h23, 8'h59, 8'h00, 2'd0}) begin
            errors++; $display("FAIL set_2359 got %h expected %h", {a_hh, a_mm, a_ss, a_mode}, {8'h23, 8'h59, 8'h00, 2'd0});
        end
        for (int k = 0; k < 59; k++) begin
            cyc(1, 0);
            for (int c = 0; c < 2; c++) begin
                checks++;
                if (obs[c] !== exp_vec(c)) begin
                    errors++; $display("FAIL count_to_235959 dut%0d step %0d got %h expected %h", c, k, obs[c], exp_vec(c));
                end
            end
        end
        cyc(1, 0);
        checks++;
        if ({a_hh, a_mm, a_ss, a_dw} !== {8'h00, 8'h00, 8'h00, 1'b1}) begin
            errors++; $display("FAIL day_wrap_24h got %h expected %h", {a_hh, a_mm, a_ss, a_dw}, {24'h0, 1'b1});
        end
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (obs[c] !== exp_vec(c)) begin
                errors++; $display("FAIL day_wrap_model dut%0d got %h expected %h", c, obs[c], exp_vec(c));
            end
        end
        cyc(0, 0);
        checks++;
        if (a_dw !== 1'b0) begin
            errors++; $display("FAIL day_wrap_pulse_width got %b expected 0", a_dw);
        end
    endtask

    task automatic test_set_hours();
        repeat (37) cyc(1, 0);
        btn_mode = 1'b1;
        repeat (3) cyc(0, 0);
        cyc(1, 1);
        btn_mode = 1'b0;
        checks++;
        if ({a_mode, a_ss, a_bh} !== {2'd1, 8'h00, 1'b0}) begin
            errors++; $display("FAIL enter_set_hh got %h expected %h", {a_mode, a_ss, a_bh}, {2'd1, 8'h00, 1'b0});
        end
        for (int k = 0; k < 6; k++) begin
            repeat (3) cyc(1, 0);
            cyc(0, 1);
            checks++;
            if (a_bh !== (k % 2 == 0)) begin
                errors++; $display("FAIL blink_hh step %0d got %b expected %b", k, a_bh, (k % 2 == 0));
            end
            for (int c = 0; c < 2; c++) begin
                checks++;
                if (obs[c] !== exp_vec(c)) begin
                    errors++; $display("FAIL blink_model dut%0d got %h expected %h", c, obs[c], exp_vec(c));
                end
            end
        end
        repeat (3) begin
            press(0, 1, 1);
            cyc(1, 0);
        end
        checks++;
        if ({a_hh, a_ss} !== {8'h03, 8'h00}) begin
            errors++; $display("FAIL set_hh_inc got %h expected 0300", {a_hh, a_ss});
        end
        press(1, 0, 0);
        press(1, 0, 0);
        checks++;
        if ({a_mode, a_mm, a_bh, a_bm} !== {2'd0, 8'h00, 2'b00}) begin
            errors++; $display("FAIL back_to_run got %h expected %h", {a_mode, a_mm, a_bh, a_bm}, {2'd0, 8'h00, 2'b00});
        end
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (obs[c] !== exp_vec(c)) begin
                errors++; $display("FAIL set_hours_model dut%0d got %h expected %h", c, obs[c], exp_vec(c));
            end
        end
    endtask

    task automatic test_simultaneous();
        repeat (5) cyc(1, 0);
        press(1, 0, 1);
        checks++;
        if ({a_mode, a_ss} !== {2'd1, 8'h00}) begin
            errors++; $display("FAIL mode_with_s_tick got %h expected 100", {a_mode, a_ss});
        end
        press(1, 1, 0);
        checks++;
        if ({a_mode, a_hh} !== {2'd2, 8'h03}) begin
            errors++; $display("FAIL mode_with_inc got %h expected 203", {a_mode, a_hh});
        end
        press(1, 0, 0);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (obs[c] !== exp_vec(c)) begin
                errors++; $display("FAIL simultaneous_model dut%0d got %h expected %h", c, obs[c], exp_vec(c));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        press(1, 0, 0);
        repeat (14) press(0, 1, 0);
        press(1, 0, 0);
        repeat (27) press(0, 1, 0);
        checks++;
        if ({a_hh, a_mm, a_mode} !== {8'h14, 8'h27, 2'd2}) begin
            errors++; $display("FAIL set_1427 got %h expected %h", {a_hh, a_mm, a_mode}, {8'h14, 8'h27, 2'd2});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs[0] !== {8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0}) begin
            errors++; $display("FAIL async_reset_24h got %h expected 0", obs[0]);
        end
        checks++;
        if (obs[1] !== {8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0}) begin
            errors++; $display("FAIL async_reset_12h got %h expected %h", obs[1], {8'h12, 21'h0});
        end
        @(negedge clk_in);
        rst_n = 1'b1;
        model_reset();
        cyc(1, 0);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (obs[c] !== exp_vec(c)) begin
                errors++; $display("FAIL after_async_reset dut%0d got %h expected %h", c, obs[c], exp_vec(c));
            end
        end
    endtask

    task automatic test_12h_wrap();
        do_reset();
        press(1, 0, 0);
        press(1, 0, 0);
        repeat (59) press(0, 1, 0);
        press(1, 0, 0);
        checks++;
        if ({b_hh, b_mm, b_ss, b_mode} !== {8'h12, 8'h59, 8'h00, 2'd0}) begin
            errors++; $display("FAIL set_1259 got %h expected %h", {b_hh, b_mm, b_ss, b_mode}, {8'h12, 8'h59, 8'h00, 2'd0});
        end
        repeat (59) cyc(1, 0);
        cyc(1, 0);
        checks++;
        if ({b_hh, b_mm, b_ss, b_dw} !== {8'h01, 8'h00, 8'h00, 1'b1}) begin
            errors++; $display("FAIL wrap_12h got %h expected %h", {b_hh, b_mm, b_ss, b_dw}, {8'h01, 16'h0, 1'b1});
        end
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (obs[c] !== exp_vec(c)) begin
                errors++; $display("FAIL wrap_12h_model dut%0d got %h expected %h", c, obs[c], exp_vec(c));
            end
        end
        cyc(0, 0);
        checks++;
        if (b_dw !== 1'b0) begin
            errors++; $display("FAIL wrap_12h_pulse_width got %b expected 0", b_dw);
        end
    endtask

    // Random buttons change only at slot start, so the synchronisers settle before the slot's hs_tick.
    task automatic test_random();
        for (int slot = 0; slot < 300; slot++) begin
            if ($urandom_range(0, 3) == 0) btn_mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) btn_inc  = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) begin
                cyc(($urandom_range(0, 2) == 0), (k == 3) && ($urandom_range(0, 1) == 1));
                for (int c = 0; c < 2; c++) begin
                    checks++;
                    if (obs[c] !== exp_vec(c)) begin
                        errors++; $display("FAIL random slot %0d dut%0d got %h expected %h", slot, c, obs[c], exp_vec(c));
                    end
                end
            end
        end
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; s_tick = 1'b0; hs_tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        test_reset();
        test_seconds_carry();
        test_day_wrap();
        test_set_hours();
        test_simultaneous();
        test_async_reset();
        test_12h_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
